mux9_rr_capture: RTL and testbench
==================================

// Module: mux9_rr_capture
// PURPOSE
//   Upstream controller and capture stage for the 9:1 x16 data mux. Arbitrates
//   round-robin among 9 requesting channels and drives the mux select. Registers
//   the selected mux output into a valid/ready output register.
//   Sits between the per-channel sources (a..i) and the downstream consumer.
// PARAMETERS
//   WIDTH     16      data width of mux_out / out_data
//   IDLE_SEL  4'hF    select driven when no channel is granted (mux outputs all-ones)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   req        in   9      level request per channel; bit k = channel k (a=0 .. i=8)
//   ack        out  9      one-hot, 1-cycle pulse: channel k's word was captured
//   sel        out  4      registered select to the 9:1 mux (0..8 grant, IDLE_SEL idle)
//   mux_out    in   WIDTH  combinational output of the 9:1 mux
//   out_data   out  WIDTH  captured word
//   out_chan   out  4      channel index of out_data
//   out_valid  out  1      out_data/out_chan valid
//   out_ready  in   1      consumer accepts when out_valid && out_ready
// BEHAVIOUR
//   Reset (sync, active-high): state=IDLE, sel=IDLE_SEL, ptr=0, ack=0,
//     out_valid=0, out_data=0, out_chan=0. Reset mid-transaction discards the
//     pending word; no ack is issued for it.
//   FSM states IDLE -> CAPTURE -> HOLD -> IDLE:
//   IDLE: if req!=0, winner = first set req bit searching ptr, ptr+1, .., 8, 0, ..
//     (mod 9); sel<=winner; go CAPTURE. If req==0, stay; sel stays IDLE_SEL.
//   CAPTURE (1 cycle): out_data<=mux_out; out_chan<=sel; out_valid<=1;
//     ack[sel]<=1 for exactly this one edge; ptr<=(sel==8)?0:sel+1; go HOLD.
//     Capture happens even if req[sel] dropped after the grant.
//   HOLD: out_data/out_chan/out_valid held stable while !out_ready.
//     On out_valid&&out_ready: out_valid<=0, sel<=IDLE_SEL, go IDLE.
//   Latency: req sampled at edge n -> sel valid after n -> out_valid and ack
//     high after edge n+1. Minimum 3 cycles per word (zero-stall consumer).
//   sel is only ever 0..8 or IDLE_SEL; ptr only ever 0..8.
//   Fairness: a continuously requesting channel is served within 9 grants.
//   ack deasserts the cycle after its pulse; sources drop req on ack if done.
//   out_ready while out_valid=0 is ignored.
// TESTING
//   1. Reset, req=0 for 5 cycles -> sel=4'hF, out_valid=0, ack=0 throughout.
//   2. req=9'h004, mux_out=16'h1234 while sel=2, out_ready=1 -> sel=2 after 1 edge;
//      out_data=16'h1234, out_chan=2, ack=9'h004 after 2nd edge; IDLE after 3rd.
//   3. req=9'h1FF held, out_ready=1 -> grant order 0,1,..,8,0 (wrap 8->0), one
//      ack per grant, one word every 3 cycles.
//   4. Grant ch 5, then out_ready=0 for 4 cycles -> out_data/out_chan=5 stable,
//      out_valid=1, sel=5, no new grant; completes on first out_ready=1 cycle.
//   5. ptr=7, req=9'h081 (ch0, ch7) -> ch7 granted first, then ch0.
//   6. reset asserted during HOLD -> next edge: out_valid=0, sel=4'hF, ptr=0,
//      no ack for the discarded word.

Source files
------------

// File: rtl/mux9_rr_capture.sv
// ---------------------------------------------------------------------------
// mux9_rr_capture
//   Upstream controller and capture stage for a 9:1 x WIDTH data mux.
//   Grants one of nine requesting channels in round-robin order, drives the
//   external mux select, and captures the selected mux output into a
//   valid/ready output register. Each grant also produces a one-cycle
//   one-hot ack back to the channel whose word was captured.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   req        in   9      level request per channel (bit k = channel k)
//   ack        out  9      one-hot 1-cycle pulse: channel k's word captured
//   sel        out  4      registered mux select (0..8 grant, IDLE_SEL idle)
//   mux_out    in   WIDTH  combinational output of the external 9:1 mux
//   out_data   out  WIDTH  captured word
//   out_chan   out  4      channel index of out_data
//   out_valid  out  1      out_data/out_chan valid
//   out_ready  in   1      consumer accepts when out_valid && out_ready
// ---------------------------------------------------------------------------
module mux9_rr_capture #(
  parameter int         WIDTH    = 16,
  parameter logic [3:0] IDLE_SEL = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [8:0]       req,
  output logic [8:0]       ack,
  output logic [3:0]       sel,
  input  logic [WIDTH-1:0] mux_out,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state_reg;
  logic [3:0] ptr_reg;     // channel with highest priority for the next grant

  // Candidate k is channel (ptr + k) mod 9, so candidate 0 has top priority.
  logic [3:0] cand_idx [9];
  logic [8:0] cand_req;
  logic [8:0] sel_onehot;

  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_cand
      logic [4:0] sum;
      assign sum           = {1'b0, ptr_reg} + 5'(gi);
      assign cand_idx[gi]  = (sum >= 5'd9) ? 4'(sum - 5'd9) : sum[3:0];
      assign cand_req[gi]  = req[cand_idx[gi]];
      assign sel_onehot[gi] = (sel == 4'(gi));
    end
  endgenerate

  // Scan from the lowest priority upwards so the highest-priority requester
  // is the last one written and therefore wins.
  logic [3:0] winner;
  always_comb begin
    winner = 4'd0;
    for (int k = 8; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner = cand_idx[k];
      end
    end
  end

  logic [3:0] ptr_after_sel;
  assign ptr_after_sel = (sel == 4'd8) ? 4'd0 : sel + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sel       <= IDLE_SEL;
      ptr_reg   <= 4'd0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= 4'd0;
    end else begin
      ack <= '0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            sel       <= winner;
            state_reg <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The word is taken even if the granted channel dropped its request.
          out_data  <= mux_out;
          out_chan  <= sel;
          out_valid <= 1'b1;
          ack       <= sel_onehot;
          ptr_reg   <= ptr_after_sel;
          state_reg <= HOLD;
        end
        HOLD: begin
          // sel stays on the granted channel until the consumer takes the word.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            sel       <= IDLE_SEL;
            state_reg <= IDLE;
          end
        end
        default: begin
          sel       <= IDLE_SEL;
          out_valid <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux9_rr_capture.sv
// ---------------------------------------------------------------------------
// tb_mux9_rr_capture
//   Self-checking bench for mux9_rr_capture. A transaction-level reference
//   (phase of the current word, rotating priority pointer, modulo-9 search)
//   predicts every registered output each cycle; directed sequences pin the
//   reference with literal expectations, then randomized traffic runs.
// ---------------------------------------------------------------------------
module tb_mux9_rr_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  req;
  logic [8:0]  ack;
  logic [3:0]  sel;
  logic [15:0] mux_out;
  logic [15:0] out_data;
  logic [3:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] chan_data [9];

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit live     = 1'b0;

  always #5 clk = ~clk;

  mux9_rr_capture #(.WIDTH(16), .IDLE_SEL(4'hF)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .ack       (ack),
    .sel       (sel),
    .mux_out   (mux_out),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // External 9:1 mux: all-ones when the select is not a channel.
  always_comb begin
    mux_out = 16'hFFFF;
    for (int k = 0; k < 9; k++) begin
      if (sel == 4'(k)) mux_out = chan_data[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rr_pick(input logic [8:0] r, input int p);
    for (int k = 0; k < 9; k++) begin
      if (r[(p + k) % 9]) return (p + k) % 9;
    end
    return -1;
  endfunction

  function automatic logic [15:0] data_of(input logic [3:0] s);
    logic [15:0] d;
    d = 16'hFFFF;
    for (int k = 0; k < 9; k++) if (s == 4'(k)) d = chan_data[k];
    return d;
  endfunction

  int          m_phase;   // 0 waiting for requests, 1 granted, 2 word offered
  int          m_ptr;
  logic [3:0]  m_sel;
  logic [8:0]  m_ack;
  logic        m_valid;
  logic [15:0] m_data;
  logic [3:0]  m_chan;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_ptr   <= 0;
      m_sel   <= 4'hF;
      m_ack   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
    end else begin
      m_ack <= '0;
      if (m_phase == 0) begin
        if (req != 9'd0) begin
          m_sel   <= 4'(rr_pick(req, m_ptr));
          m_phase <= 1;
        end
      end else if (m_phase == 1) begin
        m_data  <= data_of(m_sel);
        m_chan  <= m_sel;
        m_valid <= 1'b1;
        m_ack   <= 9'd1 << m_sel;
        m_ptr   <= (int'(m_sel) + 1) % 9;
        m_phase <= 2;
      end else begin
        if (out_ready) begin
          m_valid <= 1'b0;
          m_sel   <= 4'hF;
          m_phase <= 0;
        end
      end
    end
  end

  // Per-cycle compare of every registered output against the reference.
  always @(negedge clk) begin
    if (live) begin
      chk("model_sel",       32'(sel),       32'(m_sel));
      chk("model_ack",       32'(ack),       32'(m_ack));
      chk("model_out_valid", 32'(out_valid), 32'(m_valid));
      chk("model_out_data",  32'(out_data),  32'(m_data));
      chk("model_out_chan",  32'(out_chan),  32'(m_chan));
      if (ack != 9'd0)
        $display("capture chan=%0d data=%h cycle=%0d", out_chan, out_data, cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [8:0] v);
    for (int k = 0; k < 9; k++) if (v == (9'd1 << k)) return k;
    return -1;
  endfunction

  int grants[$];
  int gcyc[$];
  int exp3 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 0};

  initial begin
    reset     = 1'b1;
    req       = '0;
    out_ready = 1'b0;
    for (int k = 0; k < 9; k++) chan_data[k] = 16'($urandom);
    tick();
    live = 1'b1;
    chk("reset_sel",   32'(sel),       32'hF);
    chk("reset_valid", 32'(out_valid), 32'h0);
    chk("reset_ack",   32'(ack),       32'h0);
    chk("reset_data",  32'(out_data),  32'h0);
    chk("reset_chan",  32'(out_chan),  32'h0);
    reset = 1'b0;

    // 1: idle with no requests
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_sel",   32'(sel),       32'hF);
      chk("idle_valid", 32'(out_valid), 32'h0);
      chk("idle_ack",   32'(ack),       32'h0);
    end

    // 2: single request on channel 2
    chan_data[2] = 16'h1234;
    req          = 9'h004;
    out_ready    = 1'b1;
    tick();
    chk("t2_sel", 32'(sel), 32'h2);
    req = '0;
    tick();
    chk("t2_data",  32'(out_data),  32'h1234);
    chk("t2_chan",  32'(out_chan),  32'h2);
    chk("t2_ack",   32'(ack),       32'h004);
    chk("t2_valid", 32'(out_valid), 32'h1);
    tick();
    chk("t2_idle_sel",   32'(sel),       32'hF);
    chk("t2_idle_valid", 32'(out_valid), 32'h0);

    // 3: all channels requesting, zero-stall consumer
    do_reset();
    req       = 9'h1FF;
    out_ready = 1'b1;
    grants.delete();
    gcyc.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ack != 9'd0) begin
        grants.push_back(onehot_idx(ack));
        gcyc.push_back(cyc);
      end
    end
    req = '0;
    chk("t3_grant_count", 32'(grants.size()), 32'd10);
    for (int i = 0; i < 10 && i < grants.size(); i++)
      chk("t3_grant_order", 32'(grants[i]), 32'(exp3[i]));
    for (int i = 1; i < gcyc.size(); i++)
      chk("t3_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    tick();

    // 4: consumer stalls for four cycles
    do_reset();
    chan_data[5] = 16'hA5C3;
    req          = 9'h020;
    out_ready    = 1'b0;
    tick();
    chk("t4_sel", 32'(sel), 32'h5);
    req = '0;
    tick();
    chk("t4_ack", 32'(ack), 32'h020);
    chan_data[5] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_valid", 32'(out_valid), 32'h1);
      chk("t4_hold_data",  32'(out_data),  32'hA5C3);
      chk("t4_hold_chan",  32'(out_chan),  32'h5);
      chk("t4_hold_sel",   32'(sel),       32'h5);
      chk("t4_hold_ack",   32'(ack),       32'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("t4_done_valid", 32'(out_valid), 32'h0);
    chk("t4_done_sel",   32'(sel),       32'hF);

    // 5: pointer at 7 after serving channel 6, then ch0 and ch7 request
    do_reset();
    req       = 9'h040;
    out_ready = 1'b1;
    tick();
    req = '0;
    tick();
    tick();
    req = 9'h081;
    grants.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ack != 9'd0) grants.push_back(onehot_idx(ack));
    end
    req = '0;
    chk("t5_grant_count", 32'(grants.size()), 32'd2);
    if (grants.size() == 2) begin
      chk("t5_first",  32'(grants[0]), 32'd7);
      chk("t5_second", 32'(grants[1]), 32'd0);
    end
    tick();

    // 6: reset while the word is held
    do_reset();
    req       = 9'h008;
    out_ready = 1'b0;
    tick();
    req = '0;
    tick();
    tick();
    chk("t6_pre_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    tick();
    chk("t6_valid", 32'(out_valid), 32'h0);
    chk("t6_sel",   32'(sel),       32'hF);
    chk("t6_ack",   32'(ack),       32'h0);
    reset     = 1'b0;
    req       = 9'h101;   // ch0 wins only if the pointer went back to 0
    out_ready = 1'b1;
    tick();
    chk("t6_ptr_sel", 32'(sel), 32'h0);
    req = '0;
    tick();
    chk("t6_ack_after", 32'(ack), 32'h001);
    tick();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 9; k++) chan_data[k] = 16'($urandom);
      req       = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
